// File: rtl/snn_mac_pkg.sv
// Shared definitions for the spike encoder and the shift-add MAC beta interface.
package snn_mac_pkg;

  localparam int unsigned BETA_W = 4;
  localparam logic [BETA_W-1:0] BETA_MAX = 4'd8;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } enc_state_t;

  // Count after an optional increment, clamped at BETA_MAX.
  function automatic logic [BETA_W-1:0] beta_next(input logic [BETA_W-1:0] cnt, input logic inc);
    if (inc && (cnt < BETA_MAX)) begin
      return cnt + BETA_W'(1);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/beta_sat_counter.sv
// Per-neuron spike counter that saturates at BETA_MAX; sat flags an increment that was dropped.
module beta_sat_counter
  import snn_mac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [BETA_W-1:0] count,
  output logic              sat
);

  logic [BETA_W-1:0] count_q;
  logic [BETA_W-1:0] count_d;

  assign count_d = clr ? '0 : beta_next(count_q, inc);
  assign sat     = inc && !clr && (count_q == BETA_MAX);
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spike_beta_encoder.sv
// Counts spikes per neuron over a timestep, then streams (id, beta) pairs to the MAC over valid/ready.
module spike_beta_encoder
  import snn_mac_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned ID_W        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spike_valid,
  input  logic [ID_W-1:0]   spike_id,
  output logic              spike_ready,
  input  logic              step_end,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [BETA_W-1:0] out_beta,
  output logic              busy,
  output logic              sat_pulse,
  output logic              miss_pulse
);

  enc_state_t        state_q;
  logic [ID_W-1:0]   idx_q;
  logic [BETA_W-1:0] out_beta_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              sat_pulse_q;
  logic              miss_pulse_q;

  logic [BETA_W-1:0]      count [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] inc;
  logic [NUM_NEURONS-1:0] clr;
  logic [NUM_NEURONS-1:0] sat;
  logic                   accept;
  logic                   handshake;
  logic                   last;
  logic [ID_W-1:0]        idx_nxt;

  assign spike_ready = (state_q == ACCUM);
  assign accept      = spike_valid && spike_ready;
  assign handshake   = out_valid_q && out_ready;
  assign last        = (idx_q == ID_W'(NUM_NEURONS - 1));
  assign idx_nxt     = idx_q + ID_W'(1);

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_cnt
    assign inc[g] = accept && (spike_id == ID_W'(g));
    assign clr[g] = handshake && (idx_q == ID_W'(g));
    beta_sat_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[g]),
      .clr   (clr[g]),
      .count (count[g]),
      .sat   (sat[g])
    );
  end

  // FSM plus registered output/pulse generation; the first beta includes a same-cycle spike.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      idx_q        <= '0;
      out_beta_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      sat_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      sat_pulse_q  <= |sat;
      miss_pulse_q <= step_end && (state_q == DRAIN);
      case (state_q)
        ACCUM: begin
          if (step_end) begin
            state_q     <= DRAIN;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            out_beta_q  <= beta_next(count[0], inc[0]);
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (last) begin
              state_q     <= ACCUM;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              idx_q       <= '0;
              out_beta_q  <= '0;
            end else begin
              idx_q      <= idx_nxt;
              out_beta_q <= count[idx_nxt];
            end
          end
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_id     = idx_q;
  assign out_beta   = out_beta_q;
  assign busy       = busy_q;
  assign sat_pulse  = sat_pulse_q;
  assign miss_pulse = miss_pulse_q;

  a_beta_range: assert property (@(posedge clk) disable iff (reset) out_beta_q <= BETA_MAX);

endmodule

// File: tb/tb_spike_beta_encoder.sv
// Scoreboard bench for spike_beta_encoder: directed spikes, expected pairs queued, monitor compares.
module tb_spike_beta_encoder;
  import snn_mac_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned ID_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              spike_valid;
  logic [ID_W-1:0]   spike_id;
  logic              spike_ready;
  logic              step_end;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_id;
  logic [BETA_W-1:0] out_beta;
  logic              busy;
  logic              sat_pulse;
  logic              miss_pulse;

  int n_run  = 0;
  int n_fail = 0;
  int exp_q[$];
  int cyc;

  always #5 clk = ~clk;

  spike_beta_encoder #(.NUM_NEURONS(N), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_valid(spike_valid),
    .spike_id   (spike_id),
    .spike_ready(spike_ready),
    .step_end   (step_end),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_beta   (out_beta),
    .busy       (busy),
    .sat_pulse  (sat_pulse),
    .miss_pulse (miss_pulse)
  );

  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pk(input int id, input int beta);
    return id * 16 + beta;
  endfunction

  task automatic push4(input int b0, input int b1, input int b2, input int b3);
    exp_q.push_back(pk(0, b0));
    exp_q.push_back(pk(1, b1));
    exp_q.push_back(pk(2, b2));
    exp_q.push_back(pk(3, b3));
  endtask

  // Monitor: every presented pair is checked against the queue head; popped on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pair", pk(int'(out_id), int'(out_beta)), -1);
      end else if (out_ready) begin
        check("pair", pk(int'(out_id), int'(out_beta)), exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        check("pair_hold", pk(int'(out_id), int'(out_beta)), exp_q[0]);
      end
    end
  end

  task automatic spike(input int id, input int exp_sat);
    spike_valid = 1'b1;
    spike_id    = ID_W'(id);
    @(posedge clk); #1;
    spike_valid = 1'b0;
    check("sat_pulse", int'(sat_pulse), exp_sat);
  endtask

  task automatic step();
    step_end = 1'b1;
    @(posedge clk); #1;
    step_end = 1'b0;
  endtask

  task automatic drain_wait(output int c);
    c = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      c++;
    end
    if (busy) check("drain_timeout", 1, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; spike_valid = 1'b0; spike_id = '0; step_end = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_spike_ready", int'(spike_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({sat_pulse, miss_pulse}), 0);
    check("rst_out_id_beta", pk(int'(out_id), int'(out_beta)), 0);

    // 1: idle step drains all zeros in N cycles
    push4(0, 0, 0, 0);
    step();
    drain_wait(cyc);
    check("t1_drain_cycles", cyc, 4);

    // 2: mixed spikes, then an empty second step
    spike(1, 0); spike(1, 0); spike(3, 0); spike(1, 0); spike(2, 0);
    push4(0, 3, 1, 1);
    step();
    drain_wait(cyc);
    check("t2_drain_cycles", cyc, 4);
    push4(0, 0, 0, 0);
    step();
    drain_wait(cyc);

    // 3: saturation; pulses on the 9th and 10th acceptance only
    for (int k = 0; k < 10; k++) spike(2, (k >= 8) ? 1 : 0);
    @(posedge clk); #1;
    check("t3_sat_clear", int'(sat_pulse), 0);
    push4(0, 0, 8, 0);
    step();
    drain_wait(cyc);
    check("t3_drain_cycles", cyc, 4);

    // 4: backpressure with held spike, which lands in the following step
    spike(0, 0); spike(0, 0); spike(1, 0);
    push4(2, 1, 0, 0);
    out_ready = 1'b0;
    step();
    spike_valid = 1'b1; spike_id = 2'd3;
    for (int p = 0; p < 4; p++) begin
      repeat (3) @(posedge clk);
      #1 check("t4_spike_ready_drain", int'(spike_ready), 0);
      check("t4_busy_hold", int'(busy), 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    check("t4_busy_fall", int'(busy), 0);
    check("t4_spike_ready_back", int'(spike_ready), 1);
    @(posedge clk); #1;
    spike_valid = 1'b0;
    push4(0, 0, 0, 1);
    out_ready = 1'b1;
    step();
    drain_wait(cyc);
    check("t4_drain_cycles", cyc, 4);

    // 5: spike with step_end in the same cycle, then step_end during drain
    push4(1, 0, 0, 0);
    spike_valid = 1'b1; spike_id = 2'd0; step_end = 1'b1;
    @(posedge clk); #1;
    spike_valid = 1'b0;
    @(posedge clk); #1;
    step_end = 1'b0;
    check("t5_miss_pulse", int'(miss_pulse), 1);
    check("t5_busy", int'(busy), 1);
    @(posedge clk); #1;
    check("t5_miss_clear", int'(miss_pulse), 0);
    drain_wait(cyc);

    // 6: reset right after pair 1 is accepted aborts the drain
    spike(2, 0); spike(2, 0); spike(0, 0);
    exp_q.push_back(pk(0, 1));
    exp_q.push_back(pk(1, 0));
    exp_q.push_back(pk(2, 2));
    step();
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_ready && out_id == 2'd1) break;
      @(negedge clk);
    end
    check("t6_saw_pair1", int'(out_valid && out_id == 2'd1), 1);
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_busy", int'(busy), 0);
    exp_q.delete();
    out_ready = 1'b1;
    push4(0, 0, 0, 0);
    step();
    drain_wait(cyc);
    check("t6_drain_cycles", cyc, 4);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
